// File: rtl/rv32i_tb_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rv32i_tb_core
// Description : Single-cycle RV32I core with internal program ROM and data RAM,
//               loader ports for preloading and debug read ports for checking.
//               Optional retire trace outputs when RV_TRACE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_tb_core #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          PROG_WORDS = 64,
    parameter int          DATA_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_wdata,
    input  logic        data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    input  logic [4:0]  dbg_reg,
    output logic [31:0] dbg_rdata,
    output logic [31:0] pc,
    output logic        halted
`ifdef RV_TRACE_EN
    ,
    output logic        retire_valid,
    output logic [31:0] retire_pc,
    output logic [31:0] retire_insn
`endif
);

    localparam int          c_PAW        = (PROG_WORDS > 1) ? $clog2(PROG_WORDS) : 1;
    localparam int          c_DAW        = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
    localparam logic [31:0] c_PROG_BYTES = 32'(PROG_WORDS * 4);
    localparam logic [31:0] c_DATA_BYTES = 32'(DATA_WORDS * 4);

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;

    logic [31:0] r_prog_mem [PROG_WORDS];
    logic [31:0] r_data_mem [DATA_WORDS];
    logic [31:0] r_regs_q   [32];
    logic [31:0] r_pc_q, w_pc_d;
    logic        r_halted_q, w_halted_d;

    logic        w_fetch_ok, w_legal, w_rd_we, w_st_en, w_taken, w_retire;
    logic        w_is_reg, w_f7_zero, w_f7_alt, w_ld_ok, w_st_ok;
    logic [31:0] w_insn, w_rs1_val, w_rs2_val, w_alu_b, w_rd_val, w_pc_next;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_ld_addr, w_st_addr, w_ld_data;
    logic [6:0]  w_opcode, w_funct7;
    logic [4:0]  w_rd, w_rs1, w_rs2, w_shamt;
    logic [2:0]  w_funct3;

    // Fetch: the whole PC is range-checked so any address past the ROM halts.
    assign w_fetch_ok = (r_pc_q < c_PROG_BYTES);
    assign w_insn     = w_fetch_ok ? r_prog_mem[r_pc_q[c_PAW+1:2]] : 32'h0;

    assign w_opcode = w_insn[6:0];
    assign w_rd     = w_insn[11:7];
    assign w_funct3 = w_insn[14:12];
    assign w_rs1    = w_insn[19:15];
    assign w_rs2    = w_insn[24:20];
    assign w_funct7 = w_insn[31:25];

    assign w_imm_i = {{20{w_insn[31]}}, w_insn[31:20]};
    assign w_imm_s = {{20{w_insn[31]}}, w_insn[31:25], w_insn[11:7]};
    assign w_imm_b = {{19{w_insn[31]}}, w_insn[31], w_insn[7], w_insn[30:25], w_insn[11:8], 1'b0};
    assign w_imm_u = {w_insn[31:12], 12'h000};
    assign w_imm_j = {{11{w_insn[31]}}, w_insn[31], w_insn[19:12], w_insn[20], w_insn[30:21], 1'b0};

    assign w_rs1_val = (w_rs1 == 5'd0) ? 32'h0 : r_regs_q[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? 32'h0 : r_regs_q[w_rs2];
    assign w_is_reg  = (w_opcode == c_OP_REG);
    assign w_alu_b   = w_is_reg ? w_rs2_val : w_imm_i;
    assign w_shamt   = w_alu_b[4:0];
    assign w_f7_zero = (w_funct7 == 7'b0000000);
    assign w_f7_alt  = (w_funct7 == 7'b0100000);

    assign w_ld_addr = w_rs1_val + w_imm_i;
    assign w_st_addr = w_rs1_val + w_imm_s;
    assign w_ld_ok   = (w_ld_addr < c_DATA_BYTES);
    assign w_st_ok   = (w_st_addr < c_DATA_BYTES);
    assign w_ld_data = w_ld_ok ? r_data_mem[w_ld_addr[c_DAW+1:2]] : 32'h0;

    always_comb begin
        w_legal   = 1'b0;
        w_rd_we   = 1'b0;
        w_rd_val  = 32'h0;
        w_st_en   = 1'b0;
        w_taken   = 1'b0;
        w_pc_next = r_pc_q + 32'd4;
        case (w_opcode)
            c_OP_LUI: begin
                w_legal  = 1'b1;
                w_rd_we  = 1'b1;
                w_rd_val = w_imm_u;
            end
            c_OP_AUIPC: begin
                w_legal  = 1'b1;
                w_rd_we  = 1'b1;
                w_rd_val = r_pc_q + w_imm_u;
            end
            c_OP_JAL: begin
                w_legal   = 1'b1;
                w_rd_we   = 1'b1;
                w_rd_val  = r_pc_q + 32'd4;
                w_pc_next = r_pc_q + w_imm_j;
            end
            c_OP_JALR: begin
                w_legal   = (w_funct3 == 3'b000);
                w_rd_we   = 1'b1;
                w_rd_val  = r_pc_q + 32'd4;
                w_pc_next = (w_rs1_val + w_imm_i) & ~32'd1;
            end
            c_OP_BRANCH: begin
                w_legal = 1'b1;
                case (w_funct3)
                    3'b000:  w_taken = (w_rs1_val == w_rs2_val);
                    3'b001:  w_taken = (w_rs1_val != w_rs2_val);
                    3'b100:  w_taken = ($signed(w_rs1_val) <  $signed(w_rs2_val));
                    3'b101:  w_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
                    3'b110:  w_taken = (w_rs1_val <  w_rs2_val);
                    3'b111:  w_taken = (w_rs1_val >= w_rs2_val);
                    default: w_legal = 1'b0;
                endcase
                if (w_taken) begin
                    w_pc_next = r_pc_q + w_imm_b;
                end
            end
            c_OP_LOAD: begin
                w_legal  = (w_funct3 == 3'b010);
                w_rd_we  = 1'b1;
                w_rd_val = w_ld_data;
            end
            c_OP_STORE: begin
                w_legal = (w_funct3 == 3'b010);
                w_st_en = 1'b1;
            end
            c_OP_IMM, c_OP_REG: begin
                w_rd_we = 1'b1;
                // Register ops need a clean funct7; immediate ops only care on shifts.
                w_legal = !w_is_reg || w_f7_zero;
                case (w_funct3)
                    3'b000: begin
                        w_rd_val = (w_is_reg && w_f7_alt) ? (w_rs1_val - w_alu_b) : (w_rs1_val + w_alu_b);
                        w_legal  = !w_is_reg || w_f7_zero || w_f7_alt;
                    end
                    3'b001: begin
                        w_rd_val = w_rs1_val << w_shamt;
                        w_legal  = w_f7_zero;
                    end
                    3'b010:  w_rd_val = {31'h0, $signed(w_rs1_val) < $signed(w_alu_b)};
                    3'b011:  w_rd_val = {31'h0, w_rs1_val < w_alu_b};
                    3'b100:  w_rd_val = w_rs1_val ^ w_alu_b;
                    3'b110:  w_rd_val = w_rs1_val | w_alu_b;
                    3'b111:  w_rd_val = w_rs1_val & w_alu_b;
                    default: begin
                        w_rd_val = w_f7_alt ? 32'($signed(w_rs1_val) >>> w_shamt) : (w_rs1_val >> w_shamt);
                        w_legal  = w_f7_zero || w_f7_alt;
                    end
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_retire = !rst && !r_halted_q && w_fetch_ok && w_legal;

    always_comb begin
        w_pc_d     = r_pc_q;
        w_halted_d = r_halted_q;
        if (!r_halted_q) begin
            if (w_fetch_ok && w_legal) begin
                w_pc_d = w_pc_next;
            end else begin
                w_halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_q     <= RESET_PC;
            r_halted_q <= 1'b0;
        end else begin
            r_pc_q     <= w_pc_d;
            r_halted_q <= w_halted_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs_q[i] <= 32'h0;
            end
        end else if (w_retire && w_rd_we && (w_rd != 5'd0)) begin
            r_regs_q[w_rd] <= w_rd_val;
        end
    end

    always_ff @(posedge clk) begin
        if (prog_we && (prog_addr < c_PROG_BYTES)) begin
            r_prog_mem[prog_addr[c_PAW+1:2]] <= prog_wdata;
        end
    end

    // The loader write comes second so it overrides a same-cycle store to the same word.
    always_ff @(posedge clk) begin
        if (w_retire && w_st_en && w_st_ok) begin
            r_data_mem[w_st_addr[c_DAW+1:2]] <= w_rs2_val;
        end
        if (data_we && (data_addr < c_DATA_BYTES)) begin
            r_data_mem[data_addr[c_DAW+1:2]] <= data_wdata;
        end
    end

    assign data_rdata = (data_addr < c_DATA_BYTES) ? r_data_mem[data_addr[c_DAW+1:2]] : 32'h0;
    assign dbg_rdata  = (dbg_reg == 5'd0) ? 32'h0 : r_regs_q[dbg_reg];
    assign pc         = r_pc_q;
    assign halted     = r_halted_q;

`ifdef RV_TRACE_EN
    logic        r_retire_valid_q, w_retire_valid_d;
    logic [31:0] r_retire_pc_q, w_retire_pc_d, r_retire_insn_q, w_retire_insn_d;

    always_comb begin
        w_retire_valid_d = w_retire;
        w_retire_pc_d    = w_retire ? r_pc_q : 32'h0;
        w_retire_insn_d  = w_retire ? w_insn : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retire_valid_q <= 1'b0;
            r_retire_pc_q    <= 32'h0;
            r_retire_insn_q  <= 32'h0;
        end else begin
            r_retire_valid_q <= w_retire_valid_d;
            r_retire_pc_q    <= w_retire_pc_d;
            r_retire_insn_q  <= w_retire_insn_d;
        end
    end

    assign retire_valid = r_retire_valid_q;
    assign retire_pc    = r_retire_pc_q;
    assign retire_insn  = r_retire_insn_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv32i_tb_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rv32i_tb_core
// Description : Directed and randomized checks of rv32i_tb_core against an
//               instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_tb_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog_we = 1'b0, data_we = 1'b0;
    logic [31:0] prog_addr = 32'h0, prog_wdata = 32'h0;
    logic [31:0] data_addr = 32'h0, data_wdata = 32'h0;
    logic [31:0] data_rdata, dbg_rdata, pc;
    logic [4:0]  dbg_reg = 5'd0;
    logic        halted;
`ifdef RV_TRACE_EN
    logic        retire_valid;
    logic [31:0] retire_pc, retire_insn;
`endif

    rv32i_tb_core dut (
        .clk        (clk),
        .rst        (rst),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .data_we    (data_we),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .dbg_reg    (dbg_reg),
        .dbg_rdata  (dbg_rdata),
        .pc         (pc),
        .halted     (halted)
`ifdef RV_TRACE_EN
        ,
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .retire_insn  (retire_insn)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Architectural reference state
    logic [31:0] m_prog [64];
    logic [31:0] m_data [64];
    logic [31:0] m_x    [32];
    logic [31:0] m_pc;
    bit          m_halted;

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [31:0] v;
        v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), 3'd2, v[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
    endfunction
    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] enc_u(input int imm20, input int rd, input int op);
        logic [31:0] v;
        v = imm20;
        return {v[19:0], 5'(rd), 7'(op)};
    endfunction

    // Executes one instruction from the ISA rules.
    task automatic m_step();
        logic [31:0] in, a, b, ii, is, ib, ij, npc, res, ad;
        logic [4:0]  sh;
        int          op, f3, f7, rd;
        bit          wr, bad;
        if (m_pc >= 32'd256) begin
            m_halted = 1'b1;
            return;
        end
        in  = m_prog[m_pc[7:2]];
        op  = int'(in[6:0]);
        f3  = int'(in[14:12]);
        f7  = int'(in[31:25]);
        rd  = int'(in[11:7]);
        a   = m_x[in[19:15]];
        b   = m_x[in[24:20]];
        ii  = 32'($signed(in) >>> 20);
        is  = {ii[31:5], in[11:7]};
        ib  = {{20{in[31]}}, in[7], in[30:25], in[11:8], 1'b0};
        ij  = {{12{in[31]}}, in[19:12], in[20], in[30:21], 1'b0};
        npc = m_pc + 4;
        res = 0;
        wr  = 0;
        bad = 0;
        case (op)
            'h37: begin res = {in[31:12], 12'h0}; wr = 1; end
            'h17: begin res = m_pc + {in[31:12], 12'h0}; wr = 1; end
            'h6f: begin res = m_pc + 4; wr = 1; npc = m_pc + ij; end
            'h67: begin
                bad = (f3 != 0);
                res = m_pc + 4; wr = 1; npc = (a + ii) & 32'hFFFF_FFFE;
            end
            'h63: begin
                bit tk;
                tk = 0;
                case (f3)
                    0: tk = (a == b);
                    1: tk = (a != b);
                    4: tk = ($signed(a) < $signed(b));
                    5: tk = ($signed(a) >= $signed(b));
                    6: tk = (a < b);
                    7: tk = (a >= b);
                    default: bad = 1;
                endcase
                if (tk) npc = m_pc + ib;
            end
            'h03: begin
                bad = (f3 != 2);
                ad  = a + ii;
                res = (ad < 256) ? m_data[ad[7:2]] : 32'h0;
                wr  = 1;
            end
            'h23: begin
                bad = (f3 != 2);
                ad  = a + is;
                if (!bad && ad < 256) m_data[ad[7:2]] = b;
            end
            'h13, 'h33: begin
                if (op == 'h13) b = ii;
                sh = b[4:0];
                wr = 1;
                case (f3)
                    0: begin
                        res = (op == 'h33 && f7 == 'h20) ? a - b : a + b;
                        if (op == 'h33 && f7 != 0 && f7 != 'h20) bad = 1;
                    end
                    1: begin res = a << sh; bad = (f7 != 0); end
                    2: begin res = ($signed(a) < $signed(b)) ? 1 : 0; bad = (op == 'h33 && f7 != 0); end
                    3: begin res = (a < b) ? 1 : 0; bad = (op == 'h33 && f7 != 0); end
                    4: begin res = a ^ b; bad = (op == 'h33 && f7 != 0); end
                    6: begin res = a | b; bad = (op == 'h33 && f7 != 0); end
                    7: begin res = a & b; bad = (op == 'h33 && f7 != 0); end
                    default: begin
                        res = (f7 == 'h20) ? 32'($signed(a) >>> sh) : a >> sh;
                        bad = (f7 != 0 && f7 != 'h20);
                    end
                endcase
            end
            default: bad = 1;
        endcase
        if (bad) begin
            m_halted = 1'b1;
            return;
        end
        if (wr && rd != 0) m_x[rd] = res;
        m_pc = npc;
    endtask

    // Advance the model for the coming edge, then let the DUT take it.
    task automatic tick();
        if (rst) begin
            m_pc = 0;
            m_halted = 0;
            for (int i = 0; i < 32; i++) m_x[i] = 0;
        end else if (!m_halted) begin
            m_step();
        end
        if (prog_we && prog_addr < 256) m_prog[prog_addr[7:2]] = prog_wdata;
        if (data_we && data_addr < 256) m_data[data_addr[7:2]] = data_wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic put_prog(input int idx, input logic [31:0] w);
        prog_we = 1; prog_addr = 32'(idx * 4); prog_wdata = w;
        tick();
        prog_we = 0;
    endtask

    task automatic put_data(input int idx, input logic [31:0] w);
        data_we = 1; data_addr = 32'(idx * 4); data_wdata = w;
        tick();
        data_we = 0;
    endtask

    task automatic clear_prog();
        rst = 1;
        for (int i = 0; i < 64; i++) put_prog(i, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        tick();
        n_checks++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", pc); else n_pass++;
        n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else n_pass++;
        dbg_reg = 5'd1; #1;
        n_checks++; if (dbg_rdata !== 32'h0) $display("FAIL reset_x1: got %h want 0", dbg_rdata); else n_pass++;
        for (int i = 0; i < 64; i++) begin
            prog_we = 1; prog_addr = 32'(i * 4); prog_wdata = 32'h0;
            data_we = 1; data_addr = 32'(i * 4); data_wdata = 32'h0;
            tick();
        end
        prog_we = 0; data_we = 0;
    endtask

    task automatic test_jal();
        clear_prog();
        put_prog(0, enc_j(8, 1));
        put_prog(2, enc_i(5, 0, 0, 2, 'h13));
        put_prog(3, enc_i(13, 1, 0, 3, 'h67));
        rst = 0;
        tick(); tick();
        n_checks++; if (pc !== 32'd12) $display("FAIL jal_pc: got %h want 0000000c", pc); else n_pass++;
        dbg_reg = 5'd1; #1;
        n_checks++; if (dbg_rdata !== 32'd4) $display("FAIL jal_x1: got %h want 00000004", dbg_rdata); else n_pass++;
        dbg_reg = 5'd2; #1;
        n_checks++; if (dbg_rdata !== 32'd5) $display("FAIL jal_x2: got %h want 00000005", dbg_rdata); else n_pass++;
        tick();
        n_checks++; if (pc !== 32'd16) $display("FAIL jalr_pc: got %h want 00000010", pc); else n_pass++;
        dbg_reg = 5'd3; #1;
        n_checks++; if (dbg_rdata !== 32'd16) $display("FAIL jalr_x3: got %h want 00000010", dbg_rdata); else n_pass++;
    endtask

    task automatic test_and();
        clear_prog();
        put_prog(0, enc_i('hF0, 0, 0, 1, 'h13));
        put_prog(1, enc_i('h3C, 0, 0, 2, 'h13));
        put_prog(2, enc_r(0, 2, 1, 7, 3));
        rst = 0;
        tick(); tick(); tick();
        dbg_reg = 5'd3; #1;
        n_checks++; if (dbg_rdata !== 32'h30) $display("FAIL and_x3: got %h want 00000030", dbg_rdata); else n_pass++;
        n_checks++; if (pc !== 32'd12) $display("FAIL and_pc: got %h want 0000000c", pc); else n_pass++;
    endtask

    task automatic test_branch();
        clear_prog();
        put_prog(0, enc_i(7, 0, 0, 1, 'h13));
        put_prog(1, enc_i(7, 0, 0, 2, 'h13));
        put_prog(2, enc_b(8, 2, 1, 0));
        put_prog(4, enc_b(8, 2, 1, 1));
        rst = 0;
        tick(); tick(); tick();
        n_checks++; if (pc !== 32'd16) $display("FAIL beq_taken_pc: got %h want 00000010", pc); else n_pass++;
        tick();
        n_checks++; if (pc !== 32'd20) $display("FAIL bne_not_taken_pc: got %h want 00000014", pc); else n_pass++;
    endtask

    task automatic test_lw_sw();
        clear_prog();
        put_data(0, 32'hDEADBEEF);
        put_data(1, 32'h0);
        put_data(2, 32'h0);
        put_prog(0, enc_i(0, 0, 2, 5, 'h03));
        put_prog(1, enc_s(4, 5, 0));
        put_prog(2, enc_i(-1, 0, 0, 6, 'h13));
        put_prog(3, enc_i(256, 0, 2, 6, 'h03));
        put_prog(4, enc_s(256, 0, 0));
        put_prog(5, enc_s(8, 5, 0));
        rst = 0;
        tick(); tick();
        dbg_reg = 5'd5; #1;
        n_checks++; if (dbg_rdata !== 32'hDEADBEEF) $display("FAIL lw_x5: got %h want deadbeef", dbg_rdata); else n_pass++;
        data_addr = 32'd4; #1;
        n_checks++; if (data_rdata !== 32'hDEADBEEF) $display("FAIL sw_data1: got %h want deadbeef", data_rdata); else n_pass++;
        tick(); tick(); tick();
        dbg_reg = 5'd6; #1;
        n_checks++; if (dbg_rdata !== 32'h0) $display("FAIL lw_oob_x6: got %h want 0", dbg_rdata); else n_pass++;
        data_addr = 32'd0; #1;
        n_checks++; if (data_rdata !== 32'hDEADBEEF) $display("FAIL sw_oob_data0: got %h want deadbeef", data_rdata); else n_pass++;
        data_we = 1; data_addr = 32'd8; data_wdata = 32'h12345678;
        tick();
        data_we = 0; #1;
        n_checks++; if (data_rdata !== 32'h12345678) $display("FAIL loader_wins: got %h want 12345678", data_rdata); else n_pass++;
        n_checks++; if (pc !== 32'd24) $display("FAIL lw_sw_pc: got %h want 00000018", pc); else n_pass++;
    endtask

    task automatic test_x0_illegal();
        clear_prog();
        put_prog(0, enc_i(1, 0, 0, 0, 'h13));
        rst = 0;
        tick();
        dbg_reg = 5'd0; #1;
        n_checks++; if (dbg_rdata !== 32'h0) $display("FAIL x0_zero: got %h want 0", dbg_rdata); else n_pass++;
        n_checks++; if (halted !== 1'b0) $display("FAIL pre_illegal_halted: got %b want 0", halted); else n_pass++;
        tick();
        n_checks++; if (halted !== 1'b1) $display("FAIL illegal_halted: got %b want 1", halted); else n_pass++;
        tick(); tick();
        n_checks++; if (pc !== 32'd4) $display("FAIL illegal_pc_frozen: got %h want 00000004", pc); else n_pass++;
        clear_prog();
        n_checks++; if (halted !== 1'b0) $display("FAIL reset_clears_halt: got %b want 0", halted); else n_pass++;
        put_prog(0, enc_j(256, 0));
        rst = 0;
        tick();
        n_checks++; if (pc !== 32'd256 || halted !== 1'b0) $display("FAIL oob_jump: got pc %h halted %b want 00000100 0", pc, halted); else n_pass++;
        tick();
        n_checks++; if (halted !== 1'b1) $display("FAIL oob_fetch_halted: got %b want 1", halted); else n_pass++;
    endtask

    task automatic test_prog_live();
        clear_prog();
        put_prog(0, enc_i(1, 0, 0, 1, 'h13));
        rst = 0;
        prog_we = 1; prog_addr = 32'd4; prog_wdata = enc_i(9, 0, 0, 2, 'h13);
        tick();
        prog_we = 0;
        tick();
        dbg_reg = 5'd2; #1;
        n_checks++; if (dbg_rdata !== 32'd9) $display("FAIL live_write_x2: got %h want 00000009", dbg_rdata); else n_pass++;
        n_checks++; if (pc !== 32'd8 || halted !== 1'b0) $display("FAIL live_write_pc: got %h halted %b want 00000008 0", pc, halted); else n_pass++;
    endtask

    task automatic test_reset_mid();
        clear_prog();
        put_prog(0, enc_i('hF0, 0, 0, 1, 'h13));
        put_prog(1, enc_i('h3C, 0, 0, 2, 'h13));
        put_prog(2, enc_r(0, 2, 1, 7, 3));
        rst = 0;
        tick(); tick();
        dbg_reg = 5'd2; #1;
        n_checks++; if (dbg_rdata !== 32'h3C) $display("FAIL mid_pre_x2: got %h want 0000003c", dbg_rdata); else n_pass++;
        rst = 1;
        tick();
        n_checks++; if (pc !== 32'h0 || halted !== 1'b0) $display("FAIL mid_reset_pc: got %h halted %b want 0 0", pc, halted); else n_pass++;
        #1;
        n_checks++; if (dbg_rdata !== 32'h0) $display("FAIL mid_reset_x2: got %h want 0", dbg_rdata); else n_pass++;
        data_addr = 32'd0; #1;
        n_checks++; if (data_rdata !== 32'hDEADBEEF) $display("FAIL mid_reset_dmem: got %h want deadbeef", data_rdata); else n_pass++;
        rst = 0;
        tick(); tick(); tick();
        dbg_reg = 5'd3; #1;
        n_checks++; if (dbg_rdata !== 32'h30 || pc !== 32'd12) $display("FAIL mid_rerun: got x3 %h pc %h want 00000030 0000000c", dbg_rdata, pc); else n_pass++;
    endtask

    // Forward-only control flow, so every program runs into an all-zero word and halts.
    function automatic logic [31:0] rand_insn();
        int bf3 [6] = '{0, 1, 4, 5, 6, 7};
        int k   = int'($urandom_range(0, 9));
        int rd  = int'($urandom_range(0, 31));
        int rs1 = int'($urandom_range(0, 31));
        int rs2 = int'($urandom_range(0, 31));
        int f3  = int'($urandom_range(0, 7));
        int sh  = int'($urandom_range(0, 31));
        case (k)
            0, 1, 2: begin
                if (f3 == 1) return enc_i(sh, rs1, 1, rd, 'h13);
                if (f3 == 5) return enc_i(($urandom_range(0, 1) != 0 ? 'h400 : 0) + sh, rs1, 5, rd, 'h13);
                return enc_i(int'($urandom), rs1, f3, rd, 'h13);
            end
            3, 4: return enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) != 0) ? 'h20 : 0, rs2, rs1, f3, rd);
            5: return enc_u(int'($urandom), rd, ($urandom_range(0, 1) != 0) ? 'h37 : 'h17);
            6: begin
                if ($urandom_range(0, 1) != 0) return enc_i(int'($urandom_range(0, 255)), 0, 2, rd, 'h03);
                return enc_i(int'($urandom), rs1, 2, rd, 'h03);
            end
            7: begin
                if ($urandom_range(0, 1) != 0) return enc_s(int'($urandom_range(0, 255)), rs2, 0);
                return enc_s(int'($urandom), rs2, rs1);
            end
            8: return enc_b(4 * int'($urandom_range(1, 3)), rs2, rs1, bf3[$urandom_range(0, 5)]);
            default: return enc_j(4 * int'($urandom_range(1, 3)), rd);
        endcase
    endfunction

    task automatic test_random(input int iter);
        int r, w;
        rst = 1;
        for (int i = 0; i < 64; i++) begin
            prog_we = 1; prog_addr = 32'(i * 4); prog_wdata = (i < 60) ? rand_insn() : 32'h0;
            data_we = 1; data_addr = 32'(i * 4); data_wdata = $urandom;
            tick();
        end
        prog_we = 0; data_we = 0;
        rst = 0;
        for (int c = 0; c < 70; c++) begin
            tick();
            n_checks++; if (pc !== m_pc || halted !== m_halted) $display("FAIL rand%0d_pc c%0d: got %h/%b want %h/%b", iter, c, pc, halted, m_pc, m_halted); else n_pass++;
            r = int'($urandom_range(0, 31));
            dbg_reg = 5'(r); #1;
            n_checks++; if (dbg_rdata !== m_x[r]) $display("FAIL rand%0d_x%0d c%0d: got %h want %h", iter, r, c, dbg_rdata, m_x[r]); else n_pass++;
        end
        n_checks++; if (halted !== 1'b1) $display("FAIL rand%0d_end_halted: got %b want 1", iter, halted); else n_pass++;
        for (int i = 1; i < 32; i++) begin
            dbg_reg = 5'(i); #1;
            n_checks++; if (dbg_rdata !== m_x[i]) $display("FAIL rand%0d_final_x%0d: got %h want %h", iter, i, dbg_rdata, m_x[i]); else n_pass++;
        end
        for (int i = 0; i < 64; i++) begin
            w = i;
            data_addr = 32'(w * 4); #1;
            n_checks++; if (data_rdata !== m_data[w]) $display("FAIL rand%0d_dmem%0d: got %h want %h", iter, w, data_rdata, m_data[w]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_jal();
        test_and();
        test_branch();
        test_lw_sw();
        test_x0_illegal();
        test_prog_live();
        test_reset_mid();
        for (int it = 0; it < 3; it++) test_random(it);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
